// File: rtl/alu_op_sequencer_if.sv
// Request/response and ALU-drive bundle for the ALU operation sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [3:0]             req_func;
    logic [DATA_WIDTH-1:0]  req_a;
    logic [DATA_WIDTH-1:0]  req_b;
    logic [COUNT_WIDTH-1:0] req_count;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic                   rsp_overflow;
    logic [DATA_WIDTH-1:0]  alu_a;
    logic [DATA_WIDTH-1:0]  alu_b;
    logic [3:0]             alu_func;
    logic [DATA_WIDTH-1:0]  alu_c;
    logic                   alu_overflow;

    // Sequencer side.
    modport slave (
        input  req_valid, req_func, req_a, req_b, req_count, rsp_ready, alu_c, alu_overflow,
        output req_ready, rsp_valid, rsp_data, rsp_overflow, alu_a, alu_b, alu_func
    );

    // Requester, consumer and ALU side.
    modport master (
        output req_valid, req_func, req_a, req_b, req_count, rsp_ready, alu_c, alu_overflow,
        input  req_ready, rsp_valid, rsp_data, rsp_overflow, alu_a, alu_b, alu_func
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU for a programmed number of iterations, feeding
// each result back as the next A operand, and returns the final value.
module alu_op_sequencer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_op_sequencer_if.slave   bus
);
    localparam logic [3:0] FUNC_ZERO = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, stateNext;
    logic [3:0]             funcReg, funcNext;
    logic [DATA_WIDTH-1:0]  acc, accNext;
    logic [DATA_WIDTH-1:0]  bReg, bNext;
    logic [COUNT_WIDTH-1:0] remaining, remNext;
    logic                   ovfSticky, ovfNext;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            funcReg   <= FUNC_ZERO;
            acc       <= '0;
            bReg      <= '0;
            remaining <= '0;
            ovfSticky <= 1'b0;
        end else begin
            state     <= stateNext;
            funcReg   <= funcNext;
            acc       <= accNext;
            bReg      <= bNext;
            remaining <= remNext;
            ovfSticky <= ovfNext;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        stateNext = state;
        funcNext  = funcReg;
        accNext   = acc;
        bNext     = bReg;
        remNext   = remaining;
        ovfNext   = ovfSticky;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    funcNext  = bus.req_func;
                    accNext   = bus.req_a;
                    bNext     = bus.req_b;
                    ovfNext   = 1'b0;
                    remNext   = bus.req_count;
                    stateNext = (bus.req_count == '0) ? DONE : EXEC;
                end
            end
            EXEC: begin
                // ALU is combinational: its result for acc is valid this cycle.
                accNext = bus.alu_c;
                ovfNext = ovfSticky | bus.alu_overflow;
                remNext = remaining - COUNT_WIDTH'(1);
                if (remaining == COUNT_WIDTH'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.alu_a        = acc;
    assign bus.alu_b        = bReg;
    assign bus.alu_func     = funcReg;
    assign bus.rsp_data     = acc;
    assign bus.rsp_overflow = ovfSticky;
    assign bus.req_ready    = (state == IDLE);
    assign bus.rsp_valid    = (state == DONE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: ALU model, cycle-level reference model and directed ops.
module tb_alu_op_sequencer;
    localparam logic [3:0] FUNC_ADD  = 4'h0;
    localparam logic [3:0] FUNC_SUB  = 4'h1;
    localparam logic [3:0] FUNC_AND  = 4'h2;
    localparam logic [3:0] FUNC_OR   = 4'h3;
    localparam logic [3:0] FUNC_XOR  = 4'h4;
    localparam logic [3:0] FUNC_NOT  = 4'h5;
    localparam logic [3:0] FUNC_TCP  = 4'h6;
    localparam logic [3:0] FUNC_LLS  = 4'h7;
    localparam logic [3:0] FUNC_LRS  = 4'h8;
    localparam logic [3:0] FUNC_ARS  = 4'h9;
    localparam logic [3:0] FUNC_ZERO = 4'hF;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer_if #(.DATA_WIDTH(16), .COUNT_WIDTH(4)) bus ();
    alu_op_sequencer #(.DATA_WIDTH(16), .COUNT_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {overflow, result}.
    function automatic logic [16:0] aluModel(logic [3:0] f, logic [15:0] a, logic [15:0] b);
        logic [15:0] c;
        logic        o;
        c = 16'h0;
        o = 1'b0;
        case (f)
            FUNC_ADD: begin c = a + b; o = (a[15] == b[15]) && (c[15] != a[15]); end
            FUNC_SUB: begin c = a - b; o = (a[15] != b[15]) && (c[15] != a[15]); end
            FUNC_AND: c = a & b;
            FUNC_OR:  c = a | b;
            FUNC_XOR: c = a ^ b;
            FUNC_NOT: c = ~a;
            FUNC_TCP: c = -a;
            FUNC_LLS: c = {a[14:0], 1'b0};
            FUNC_LRS: c = {1'b0, a[15:1]};
            FUNC_ARS: c = {a[15], a[15:1]};
            default:  c = 16'h0;
        endcase
        return {o, c};
    endfunction

    always_comb begin
        {bus.alu_overflow, bus.alu_c} = aluModel(bus.alu_func, bus.alu_a, bus.alu_b);
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: whole result trajectory precomputed at acceptance.
    int          edgeCnt = 0;
    int          mAccept = 0;
    int          mCount  = 0;
    bit          mBusy   = 1'b0;
    logic [3:0]  mFunc   = FUNC_ZERO;
    logic [15:0] mB      = 16'h0;
    logic [15:0] traj  [0:15];
    logic        trajO [0:15];

    initial begin
        traj[0]  = 16'h0;
        trajO[0] = 1'b0;
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            mBusy    = 1'b0;
            mFunc    = FUNC_ZERO;
            mB       = 16'h0;
            mCount   = 0;
            mAccept  = edgeCnt;
            traj[0]  = 16'h0;
            trajO[0] = 1'b0;
        end else if (!mBusy) begin
            if (bus.req_valid) begin
                logic [16:0] r;
                mBusy    = 1'b1;
                mAccept  = edgeCnt;
                mCount   = int'(bus.req_count);
                mFunc    = bus.req_func;
                mB       = bus.req_b;
                traj[0]  = bus.req_a;
                trajO[0] = 1'b0;
                for (int i = 1; i <= mCount; i++) begin
                    r        = aluModel(mFunc, traj[i-1], mB);
                    traj[i]  = r[15:0];
                    trajO[i] = trajO[i-1] | r[16];
                end
            end
        end else if ((edgeCnt - 1 - mAccept) >= mCount && bus.rsp_ready) begin
            mBusy = 1'b0;
        end
        edgeCnt++;
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (edgeCnt > 0) begin
                int k;
                int idx;
                k   = edgeCnt - 1 - mAccept;
                idx = (k < mCount) ? k : mCount;
                check("m_req_ready", 32'(bus.req_ready), 32'(!mBusy));
                check("m_rsp_valid", 32'(bus.rsp_valid), 32'(mBusy && k >= mCount));
                check("m_alu_a",     32'(bus.alu_a),     32'(traj[idx]));
                check("m_rsp_data",  32'(bus.rsp_data),  32'(traj[idx]));
                check("m_rsp_ovf",   32'(bus.rsp_overflow), 32'(trajO[idx]));
                check("m_alu_b",     32'(bus.alu_b),     32'(mB));
                check("m_alu_func",  32'(bus.alu_func),  32'(mFunc));
            end
        end
    end

    // Present a request and return at the negedge after its acceptance edge.
    task automatic startOp(logic [3:0] f, logic [15:0] a, logic [15:0] b, logic [3:0] cnt);
        int n;
        bus.req_func  = f;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_count = cnt;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = 16'hDEAD;
        bus.req_b     = 16'hBEEF;
        bus.req_func  = FUNC_TCP;
        bus.req_count = 4'hA;
    endtask

    task automatic waitRsp(string nm, logic [3:0] f, int cnt, logic [15:0] expD, logic expO);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            check({nm, "_exec_func"}, 32'(bus.alu_func), 32'(f));
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'(cnt));
        check({nm, "_data"}, 32'(bus.rsp_data), 32'(expD));
        check({nm, "_ovf"}, 32'(bus.rsp_overflow), 32'(expO));
    endtask

    task automatic finishRsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_func  = FUNC_ADD;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.req_count = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_alu_func",  32'(bus.alu_func),  32'(FUNC_ZERO));
        check("rst_alu_a",     32'(bus.alu_a),     32'h0);
        check("rst_rsp_ovf",   32'(bus.rsp_overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        startOp(FUNC_ADD, 16'h0003, 16'h0002, 4'd4);
        waitRsp("add4", FUNC_ADD, 4, 16'h000B, 1'b0);
        finishRsp();

        startOp(FUNC_LLS, 16'h0001, 16'h0000, 4'd15);
        waitRsp("lls15", FUNC_LLS, 15, 16'h8000, 1'b0);
        finishRsp();

        startOp(FUNC_ARS, 16'h8000, 16'h0000, 4'd3);
        waitRsp("ars3", FUNC_ARS, 3, 16'hF000, 1'b0);
        finishRsp();

        startOp(FUNC_ADD, 16'h7FFF, 16'h0001, 4'd2);
        waitRsp("add_ovf", FUNC_ADD, 2, 16'h8001, 1'b1);
        finishRsp();

        startOp(FUNC_SUB, 16'h1234, 16'h0005, 4'd0);
        waitRsp("cnt0", FUNC_SUB, 0, 16'h1234, 1'b0);
        finishRsp();

        startOp(4'hE, 16'h0005, 16'h0007, 4'd1);
        waitRsp("undef", 4'hE, 1, 16'h0000, 1'b0);
        finishRsp();

        // Backpressure with a request waiting behind the response.
        startOp(FUNC_SUB, 16'h0010, 16'h0003, 4'd3);
        waitRsp("bp", FUNC_SUB, 3, 16'h0007, 1'b0);
        bus.req_func  = FUNC_XOR;
        bus.req_a     = 16'h00FF;
        bus.req_b     = 16'h0F0F;
        bus.req_count = 4'd2;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            check("bp_rsp_data",  32'(bus.rsp_data),  32'h0007);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("bp_idle_ready", 32'(bus.req_ready), 32'd1);
        check("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waitRsp("bp_next", FUNC_XOR, 2, 16'h00FF, 1'b0);
        finishRsp();

        // Reset during the second EXEC cycle discards the operation.
        startOp(FUNC_ADD, 16'h0001, 16'h0001, 4'd8);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_alu_func",  32'(bus.alu_func),  32'(FUNC_ZERO));
        check("abort_alu_a",     32'(bus.alu_a),     32'h0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
